hawk_axi_rd_arb: RTL
====================

# hawk_axi_rd_arb

Round-robin arbiter that shares the single Hawk AXI4 read master between the page-read sub-engines: ATT/list lookup, compression manager, decompression manager and zero-page compacter. It replaces per-state muxing of the read request and response path. Ownership is locked from AR grant until the owner's last read beat, so exactly one read burst is outstanding at any time. Response beats are routed back only to the owning requester.

## Interface
- NUM_REQ, 4, number of requesters; index 0 = lookup, 1 = compress, 2 = decompress, 3 = compacter
- ADDR_W, `HACD_AXI4_ADDR_WIDTH, AXI address width
- DATA_W, `HACD_AXI4_DATA_WIDTH, AXI data width
- WDOG_CYCLES, 1024, watchdog limit (used only with the watchdog macro)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_arvalid_i  in  NUM_REQ  per-requester read request
- req_addr_i  in  NUM_REQ*ADDR_W  per-requester address, packed with requester 0 in the LSBs
- req_arlen_i  in  NUM_REQ*8  per-requester burst length minus 1
- req_arready_o  out  NUM_REQ  one-hot accept pulse
- req_rvalid_o  out  NUM_REQ  one-hot beat valid, asserted to the owner only
- req_rdata_o  out  DATA_W  broadcast read data
- req_rresp_o  out  2  broadcast response
- req_rlast_o  out  1  broadcast last flag
- req_rready_i  in  NUM_REQ  per-requester ready
- m_arvalid_o / m_araddr_o / m_arlen_o  out  1/ADDR_W/8  master AR channel
- m_arready_i  in  1  master AR ready
- m_rvalid_i / m_rdata_i / m_rresp_i / m_rlast_i  in  1/DATA_W/2/1  master R channel
- m_rready_o  out  1  master R ready
- busy_o  out  1  state is not IDLE
- owner_o  out  clog2(NUM_REQ)  current or last grantee
- proto_err_o  out  1  sticky beat-count error
- err_clr_i  in  1  clears proto_err_o and wdog_timeout_o
- wdog_timeout_o  out  1  sticky watchdog flag

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: when any req_arvalid_i is set, pick a grantee with round-robin, searching from last_grant+1. Latch owner, address and arlen. Clear the beat counter. Go to ADDR.
- ADDR: m_arvalid_o=1 and is held with stable address and length. When m_arready_i=1: req_arready_o[owner]=m_arready_i in the same cycle, last_grant<=owner, go to DATA.
- DATA:
  - m_rready_o = req_rready_i[owner].
  - req_rvalid_o[owner] = m_rvalid_i; all other bits are 0.
  - Data, resp and last pass through combinationally.
  - Each handshake increments the 8-bit beat counter.
  - Handshake with m_rlast_i=1 returns the FSM to IDLE.
- Requesters must hold arvalid, address and arlen stable until their arready pulse. Requests from non-owners stay pending and are never dropped.
- Beat checking:
  - Early rlast (counter < arlen): set proto_err_o; the transaction still ends.
  - Beat counter > arlen without rlast: set proto_err_o; keep waiting for rlast.
- Nonzero rresp is passed through unmodified and is not flagged by this block.
- err_clr_i and a simultaneous error event: the set wins.

## Timing
- Reset values: FSM in IDLE; every output is 0 (including owner_o); last_grant=NUM_REQ-1, so requester 0 wins first.
- Request seen in IDLE at cycle 0 → m_arvalid_o=1 at cycle 1. Minimum AR latency is 1 cycle.
- Final-beat handshake at cycle N → IDLE at N+1 → next m_arvalid_o at N+2. There is one bubble between bursts.
- The arready and rvalid paths are combinational from master to requester. There is no added response latency.
- Reset asserted mid-burst: return immediately to the reset state. Any AXI-side recovery is the system's responsibility.
- Fairness: with all four requesters continuously active, grants rotate 0,1,2,3,0…

## Configuration
- HAWK_RD_ARB_WDOG_EN defined:
  - A 16-bit counter runs while in ADDR or DATA and is cleared on every AR or R handshake.
  - When it reaches WDOG_CYCLES, wdog_timeout_o is set (sticky). FSM flow is unchanged.
- HAWK_RD_ARB_WDOG_EN undefined: no counter; wdog_timeout_o is tied to 0.

## Structure
- In hawk_rd_pkg: arb_state_t enum, requester id localparams (RD_REQ_LKUP/COMP/DECOMP/CMPT), and ARB_NUM_REQ.
- One sub-module: hawk_rr_picker, a combinational round-robin picker that takes a request vector and last_grant and returns a grant index and a valid flag.

## Test plan
- Single request, requester 2, addr 0x8000_1000, arlen 0 → m_arvalid_o at cycle 1; req_rvalid_o=4'b0100 on the beat; IDLE after rlast; proto_err_o=0.
- All four requesters active continuously, arlen 0, arready always 1 → grant order 0,1,2,3,0; each burst occupies 3 cycles (grant, AR, R).
- Requester 1 with arlen 3 (4 beats), owner rready toggling → exactly 4 beats delivered only to requester 1; m_rready_o follows req_rready_i[1].
- rlast on beat 2 of an arlen 3 burst → proto_err_o=1 and FSM in IDLE; err_clr_i pulse → proto_err_o=0.
- rst_i asserted while in DATA → all outputs 0 next cycle; first post-reset grant goes to requester 0.
- With HAWK_RD_ARB_WDOG_EN, WDOG_CYCLES=16 and arready held at 0 → wdog_timeout_o=1 after 16 cycles in ADDR; without the macro it stays 0.

Source files
------------

// File: rtl/hawk_rd_pkg.sv
// Shared definitions for the Hawk AXI read arbiter.
// Contents:
//   ARB_NUM_REQ      - number of page-read sub-engines sharing the read master
//   RD_REQ_*         - requester indices (bit position in every per-requester vector)
//   arb_state_t      - arbiter FSM state encoding
package hawk_rd_pkg;

  localparam int unsigned ARB_NUM_REQ = 4;

  localparam int unsigned RD_REQ_LKUP   = 0;  // ATT/list lookup
  localparam int unsigned RD_REQ_COMP   = 1;  // compression manager
  localparam int unsigned RD_REQ_DECOMP = 2;  // decompression manager
  localparam int unsigned RD_REQ_CMPT   = 3;  // zero-page compacter

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } arb_state_t;

endpackage

// File: rtl/hawk_rr_picker.sv
// Combinational round-robin picker.
// Searches req_i starting at last_grant_i+1 (wrapping) and returns the first
// requester found.
// Ports:
//   req_i        - request vector, one bit per requester
//   last_grant_i - index of the previous grantee
//   grant_o      - chosen index (0 when valid_o is low)
//   valid_o      - at least one request is pending
module hawk_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               valid_o
);

  logic [IDX_W:0] w_idx;

  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    w_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      // last_grant + i never exceeds 2*NUM_REQ-1, so one subtraction wraps it.
      w_idx = {1'b0, last_grant_i} + (IDX_W + 1)'(i);
      if (w_idx >= (IDX_W + 1)'(NUM_REQ)) begin
        w_idx = w_idx - (IDX_W + 1)'(NUM_REQ);
      end
      if (!valid_o && req_i[w_idx[IDX_W-1:0]]) begin
        valid_o = 1'b1;
        grant_o = w_idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/hawk_axi_rd_arb.sv
// Round-robin arbiter sharing the single Hawk AXI4 read master between the
// page-read sub-engines. Ownership is held from AR grant until the owner's
// last read beat, so exactly one burst is outstanding. R beats go only to
// the owner; data/resp/last are broadcast (zeroed outside DATA).
// Ports:
//   clk_i, rst_i                      - clock, async active-high reset
//   req_arvalid_i/addr_i/arlen_i      - per-requester AR requests (req 0 in LSBs)
//   req_arready_o                     - one-hot accept pulse to the owner
//   req_rvalid_o/rdata_o/rresp_o/rlast_o, req_rready_i - requester R side
//   m_ar*, m_arready_i                - master AR channel
//   m_r*, m_rready_o                  - master R channel
//   busy_o, owner_o                   - status
//   proto_err_o, wdog_timeout_o       - sticky error flags, cleared by err_clr_i
// Build option: define HAWK_RD_ARB_WDOG_EN to enable the stall watchdog;
// otherwise wdog_timeout_o is tied to 0.
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 64
`endif
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 128
`endif

module hawk_axi_rd_arb
  import hawk_rd_pkg::*;
#(
  parameter int NUM_REQ     = ARB_NUM_REQ,
  parameter int ADDR_W      = `HACD_AXI4_ADDR_WIDTH,
  parameter int DATA_W      = `HACD_AXI4_DATA_WIDTH,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_arvalid_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*8-1:0]        req_arlen_i,
  output logic [NUM_REQ-1:0]          req_arready_o,
  output logic [NUM_REQ-1:0]          req_rvalid_o,
  output logic [DATA_W-1:0]           req_rdata_o,
  output logic [1:0]                  req_rresp_o,
  output logic                        req_rlast_o,
  input  logic [NUM_REQ-1:0]          req_rready_i,
  output logic                        m_arvalid_o,
  output logic [ADDR_W-1:0]           m_araddr_o,
  output logic [7:0]                  m_arlen_o,
  input  logic                        m_arready_i,
  input  logic                        m_rvalid_i,
  input  logic [DATA_W-1:0]           m_rdata_i,
  input  logic [1:0]                  m_rresp_i,
  input  logic                        m_rlast_i,
  output logic                        m_rready_o,
  output logic                        busy_o,
  output logic [$clog2(NUM_REQ)-1:0]  owner_o,
  output logic                        proto_err_o,
  input  logic                        err_clr_i,
  output logic                        wdog_timeout_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // The watchdog counter is 16 bits wide.
  if (WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_bad_wdog
    $error("hawk_axi_rd_arb: WDOG_CYCLES must be in 1..65535");
  end

  arb_state_t        r_state;
  logic [IDX_W-1:0]  r_owner;
  logic [IDX_W-1:0]  r_last_grant;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [7:0]        r_beat;
  logic              r_proto_err;

  logic [IDX_W-1:0]  w_grant;
  logic              w_grant_vld;
  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_err_early;
  logic              w_err_over;

  hawk_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i        (req_arvalid_i),
    .last_grant_i (r_last_grant),
    .grant_o      (w_grant),
    .valid_o      (w_grant_vld)
  );

  assign w_ar_hs = (r_state == StAddr) && m_arready_i;
  assign w_r_hs  = (r_state == StData) && m_rvalid_i && req_rready_i[r_owner];

  // r_beat counts completed beats, so it equals the index of the current beat.
  assign w_err_early = w_r_hs && m_rlast_i && (r_beat < r_len);
  assign w_err_over  = w_r_hs && !m_rlast_i && (r_beat >= r_len);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= StIdle;
      r_owner      <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_addr       <= '0;
      r_len        <= '0;
      r_beat       <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      // Set takes priority over a simultaneous clear.
      r_proto_err <= (r_proto_err & ~err_clr_i) | w_err_early | w_err_over;
      unique case (r_state)
        StIdle: begin
          if (w_grant_vld) begin
            r_owner <= w_grant;
            r_addr  <= req_addr_i[int'(w_grant)*ADDR_W +: ADDR_W];
            r_len   <= req_arlen_i[int'(w_grant)*8 +: 8];
            r_beat  <= '0;
            r_state <= StAddr;
          end
        end
        StAddr: begin
          if (m_arready_i) begin
            r_last_grant <= r_owner;
            r_state      <= StData;
          end
        end
        StData: begin
          if (w_r_hs) begin
            if (r_beat != 8'hFF) begin
              r_beat <= r_beat + 8'd1;
            end
            if (m_rlast_i) begin
              r_state <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    req_arready_o = '0;
    req_rvalid_o  = '0;
    req_rdata_o   = '0;
    req_rresp_o   = '0;
    req_rlast_o   = 1'b0;
    m_rready_o    = 1'b0;
    if (r_state == StAddr) begin
      req_arready_o[r_owner] = m_arready_i;
    end
    if (r_state == StData) begin
      req_rvalid_o[r_owner] = m_rvalid_i;
      req_rdata_o           = m_rdata_i;
      req_rresp_o           = m_rresp_i;
      req_rlast_o           = m_rlast_i;
      m_rready_o            = req_rready_i[r_owner];
    end
  end

  assign m_arvalid_o = (r_state == StAddr);
  assign m_araddr_o  = r_addr;
  assign m_arlen_o   = r_len;
  assign busy_o      = (r_state != StIdle);
  assign owner_o     = r_owner;
  assign proto_err_o = r_proto_err;

`ifdef HAWK_RD_ARB_WDOG_EN
  logic [15:0] r_wdog_cnt;
  logic        r_wdog;
  logic        w_wdog_run;
  logic        w_wdog_hit;

  // Counts stalled cycles; any handshake shows forward progress.
  assign w_wdog_run = (r_state != StIdle) && !w_ar_hs && !w_r_hs;
  assign w_wdog_hit = w_wdog_run && ((r_wdog_cnt + 16'd1) >= 16'(WDOG_CYCLES));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wdog_cnt <= '0;
      r_wdog     <= 1'b0;
    end else begin
      r_wdog <= (r_wdog & ~err_clr_i) | w_wdog_hit;
      if (!w_wdog_run) begin
        r_wdog_cnt <= '0;
      end else if (r_wdog_cnt != 16'(WDOG_CYCLES)) begin
        r_wdog_cnt <= r_wdog_cnt + 16'd1;
      end
    end
  end

  assign wdog_timeout_o = r_wdog;
`else
  assign wdog_timeout_o = 1'b0;
`endif

endmodule
